// File: rtl/div_pkg.sv
// Shared definitions for the iterative XLEN divider: FSM states, opcodes and
// the parameter legality rule used at elaboration.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam logic [1:0] OPC_DIV  = 2'd0;
  localparam logic [1:0] OPC_DIVU = 2'd1;
  localparam logic [1:0] OPC_REM  = 2'd2;
  localparam logic [1:0] OPC_REMU = 2'd3;

  function automatic bit div_params_legal(int unsigned xlen, int unsigned unroll);
    return ((xlen == 32) || (xlen == 64)) &&
           ((unroll == 1) || (unroll == 2) || (unroll == 4)) &&
           ((xlen % unroll) == 0);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and shift the resulting quotient bit in.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            ge;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {2'b00, divisor};
    ge      = shifted >= {2'b00, divisor};
    rem_out = ge ? (XLEN+1)'(diff) : (XLEN+1)'(shifted);
    quo_out = {quo_in[XLEN-2:0], ge};
  end

endmodule

// File: rtl/divider_xlen.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with divide-by-zero and
// overflow bypass and a one-entry result cache for the companion opcode.
module divider_xlen
  import div_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_start_div,
  input  logic [1:0]      dec_div_opc,
  input  logic [XLEN-1:0] dec_src1,
  input  logic [XLEN-1:0] dec_src2,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            wrb_restart,
  output logic            div_busy,
  output logic            div_ready,
  output logic [XLEN-1:0] div_result
);

  localparam int unsigned ITERS = XLEN / UNROLL;
  localparam int unsigned CW    = $clog2(ITERS);

  if (!div_params_legal(XLEN, UNROLL)) begin : g_bad_params
    $error("divider_xlen: illegal XLEN/UNROLL combination");
  end

  div_state_e      state;
  logic [1:0]      opc_q;
  logic [4:0]      rs1_q, rs2_q;
  logic            cache_valid;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] res_quot, res_rem;

  logic [XLEN:0]   rem_chain [UNROLL+1];
  logic [XLEN-1:0] quo_chain [UNROLL+1];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_chain
    div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_chain[i]),
      .quo_in  (quo_chain[i]),
      .divisor (divisor_q),
      .rem_out (rem_chain[i+1]),
      .quo_out (quo_chain[i+1])
    );
  end

  logic            is_signed, src1_neg, src2_neg;
  logic            div_zero, overflow, hit;
  logic [XLEN-1:0] most_neg, abs1, abs2, quo_fix, rem_fix;

  // Operand classification; hit requires the same sign-ness so only Q<->R swaps.
  assign is_signed = ~dec_div_opc[0];
  assign src1_neg  = is_signed & dec_src1[XLEN-1];
  assign src2_neg  = is_signed & dec_src2[XLEN-1];
  assign most_neg  = {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero  = (dec_src2 == '0);
  assign overflow  = is_signed & (dec_src1 == most_neg) & (&dec_src2);
  assign hit       = (state == S_DONE) & cache_valid & (dec_rs1 == rs1_q) &
                     (dec_rs2 == rs2_q) & (dec_div_opc[0] == opc_q[0]);
  assign abs1      = src1_neg ? -dec_src1 : dec_src1;
  assign abs2      = src2_neg ? -dec_src2 : dec_src2;
  assign quo_fix   = neg_q ? -quo_q : quo_q;
  assign rem_fix   = neg_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      opc_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      cache_valid <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt         <= '0;
      res_quot    <= '0;
      res_rem     <= '0;
      div_busy    <= 1'b0;
      div_ready   <= 1'b0;
      div_result  <= '0;
    end else if (wrb_restart) begin
      state       <= S_IDLE;
      cache_valid <= 1'b0;
      div_busy    <= 1'b0;
      div_ready   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (dec_start_div) begin
            opc_q <= dec_div_opc;
            if (hit) begin
              div_result <= dec_div_opc[1] ? res_rem : res_quot;
            end else begin
              rs1_q <= dec_rs1;
              rs2_q <= dec_rs2;
              if (div_zero || overflow) begin
                res_quot    <= div_zero ? '1 : dec_src1;
                res_rem     <= div_zero ? dec_src1 : '0;
                div_result  <= dec_div_opc[1] ? (div_zero ? dec_src1 : '0)
                                              : (div_zero ? '1 : dec_src1);
                cache_valid <= 1'b1;
                state       <= S_DONE;
                div_busy    <= 1'b0;
                div_ready   <= 1'b1;
              end else begin
                quo_q     <= abs1;
                rem_q     <= '0;
                divisor_q <= abs2;
                neg_q     <= src1_neg ^ src2_neg;
                neg_r     <= src1_neg;
                cnt       <= '0;
                state     <= S_ITER;
                div_busy  <= 1'b1;
                div_ready <= 1'b0;
              end
            end
          end else if (state == S_DONE) begin
            state     <= S_IDLE;
            div_ready <= 1'b0;
          end
        end
        S_ITER: begin
          rem_q <= rem_chain[UNROLL];
          quo_q <= quo_chain[UNROLL];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(ITERS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          res_quot    <= quo_fix;
          res_rem     <= rem_fix;
          div_result  <= opc_q[1] ? rem_fix : quo_fix;
          cache_valid <= 1'b1;
          state       <= S_DONE;
          div_busy    <= 1'b0;
          div_ready   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_xlen.sv
// Directed and random checks of divider_xlen in three configurations
// (32/1, 32/4, 64/1) against a plain-arithmetic reference model.
module tb_divider_xlen;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset, restart;
  logic [2:0]  start;
  logic [1:0]  opc;
  logic [63:0] src1, src2;
  logic [4:0]  rs1, rs2;
  logic [2:0]  busy, ready;
  logic [31:0] res_a, res_b;
  logic [63:0] res_c;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  divider_xlen #(.XLEN(32), .UNROLL(1)) u_a (
    .clk(clk), .reset(reset), .dec_start_div(start[0]), .dec_div_opc(opc),
    .dec_src1(src1[31:0]), .dec_src2(src2[31:0]), .dec_rs1(rs1), .dec_rs2(rs2),
    .wrb_restart(restart), .div_busy(busy[0]), .div_ready(ready[0]), .div_result(res_a));

  divider_xlen #(.XLEN(32), .UNROLL(4)) u_b (
    .clk(clk), .reset(reset), .dec_start_div(start[1]), .dec_div_opc(opc),
    .dec_src1(src1[31:0]), .dec_src2(src2[31:0]), .dec_rs1(rs1), .dec_rs2(rs2),
    .wrb_restart(restart), .div_busy(busy[1]), .div_ready(ready[1]), .div_result(res_b));

  divider_xlen #(.XLEN(64), .UNROLL(1)) u_c (
    .clk(clk), .reset(reset), .dec_start_div(start[2]), .dec_div_opc(opc),
    .dec_src1(src1), .dec_src2(src2), .dec_rs1(rs1), .dec_rs2(rs2),
    .wrb_restart(restart), .div_busy(busy[2]), .div_ready(ready[2]), .div_result(res_c));

  function automatic logic [63:0] get_res(int d);
    case (d)
      0:       return {32'h0, res_a};
      1:       return {32'h0, res_b};
      default: return res_c;
    endcase
  endfunction

  function automatic logic [63:0] width_mask(int xlen);
    return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_special(int xlen, logic [1:0] op, logic [63:0] a_in, logic [63:0] b_in);
    logic [63:0] m, a, b;
    m = width_mask(xlen);
    a = a_in & m;
    b = b_in & m;
    return (b == 64'h0) || (!op[0] && (a == (m ^ (m >> 1))) && (b == m));
  endfunction

  // Reference: RISC-V M-extension division semantics in plain integer arithmetic.
  function automatic logic [63:0] ref_result(int xlen, logic [1:0] op, logic [63:0] a_in, logic [63:0] b_in);
    logic [63:0] m, a, b, q, r;
    logic [31:0] q32, r32;
    int          sa, sb;
    longint      la, lb;
    m = width_mask(xlen);
    a = a_in & m;
    b = b_in & m;
    if (b == 64'h0) begin
      q = m;
      r = a;
    end else if (op[0]) begin
      q = a / b;
      r = a % b;
    end else if ((a == (m ^ (m >> 1))) && (b == m)) begin
      q = a;
      r = 64'h0;
    end else if (xlen == 32) begin
      sa  = signed'(a[31:0]);
      sb  = signed'(b[31:0]);
      q32 = sa / sb;
      r32 = sa % sb;
      q   = {32'h0, q32};
      r   = {32'h0, r32};
    end else begin
      la = signed'(a);
      lb = signed'(b);
      q  = la / lb;
      r  = la % lb;
    end
    return op[1] ? r : q;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one op to DUT d and check busy, latency, ready and result.
  task automatic do_op(input int d, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r1, input logic [4:0] r2,
                       input bit exp_hit, input string tag);
    int          xl, un, exp_lat, lat;
    logic [63:0] exp_res;
    xl      = (d == 2) ? 64 : 32;
    un      = (d == 1) ? 4 : 1;
    exp_res = ref_result(xl, op, a, b);
    exp_lat = (exp_hit || is_special(xl, op, a, b)) ? 1 : xl / un + 2;
    opc = op; src1 = a; src2 = b; rs1 = r1; rs2 = r2;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    lat = 1;
    check({tag, "/busy"}, 64'(busy[d]), 64'(exp_lat > 1));
    while (!ready[d] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/ready"}, 64'(ready[d]), 64'h1);
    check({tag, "/result"}, get_res(d), exp_res);
  endtask

  initial begin
    logic [63:0] held, ra, rb;
    logic [1:0]  rop;
    bit          seen;
    reset = 1'b1; restart = 1'b0; start = '0; opc = '0;
    src1 = '0; src2 = '0; rs1 = '0; rs2 = '0;
    tick(3);
    for (int d = 0; d < 3; d++) begin
      check("reset/busy", 64'(busy[d]), 64'h0);
      check("reset/ready", 64'(ready[d]), 64'h0);
      check("reset/result", get_res(d), 64'h0);
    end
    reset = 1'b0;
    tick(1);

    // Full-latency DIVU followed by a cache hit on the companion REMU.
    do_op(0, OPC_DIVU, 64'd100, 64'd7, 5'd1, 5'd2, 1'b0, "divu_100_7");
    do_op(0, OPC_REMU, 64'd100, 64'd7, 5'd1, 5'd2, 1'b1, "remu_hit");
    held = get_res(0);
    tick(1);
    check("done_to_idle/ready", 64'(ready[0]), 64'h0);
    check("done_to_idle/hold", get_res(0), held);

    do_op(0, OPC_DIV, 64'hFFFF_FFF9, 64'd2, 5'd3, 5'd4, 1'b0, "div_m7_2");
    tick(1);
    do_op(0, OPC_REM, 64'hFFFF_FFF9, 64'd2, 5'd5, 5'd6, 1'b0, "rem_m7_2");
    do_op(1, OPC_DIV, 64'hFFFF_FFF9, 64'd2, 5'd3, 5'd4, 1'b0, "u4_div_m7_2");

    tick(1);
    do_op(0, OPC_DIV, 64'd5, 64'd0, 5'd7, 5'd8, 1'b0, "div_5_0");
    tick(1);
    do_op(0, OPC_REMU, 64'd5, 64'd0, 5'd9, 5'd10, 1'b0, "remu_5_0");
    tick(1);
    do_op(0, OPC_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 5'd11, 5'd12, 1'b0, "div_ovf");
    tick(1);
    do_op(0, OPC_REM, 64'h8000_0000, 64'hFFFF_FFFF, 5'd13, 5'd14, 1'b0, "rem_ovf");

    // Restart during ITER cycle 10, then the companion op must recompute.
    tick(1);
    opc = OPC_DIVU; src1 = 64'd1000; src2 = 64'd3; rs1 = 5'd15; rs2 = 5'd16;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(9);
    check("restart/busy_before", 64'(busy[0]), 64'h1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart/busy", 64'(busy[0]), 64'h0);
    check("restart/ready", 64'(ready[0]), 64'h0);
    do_op(0, OPC_REMU, 64'd1000, 64'd3, 5'd15, 5'd16, 1'b0, "remu_after_restart");

    tick(1);
    do_op(2, OPC_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd1, 5'd2, 1'b0, "x64_divu");

    // Synchronous reset in the middle of a 64-bit operation.
    tick(1);
    opc = OPC_DIVU; src1 = 64'h1234_5678_9ABC_DEF0; src2 = 64'd7; rs1 = 5'd3; rs2 = 5'd4;
    start[2] = 1'b1;
    tick(1);
    start[2] = 1'b0;
    tick(20);
    check("midreset/busy_before", 64'(busy[2]), 64'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset/busy", 64'(busy[2]), 64'h0);
    check("midreset/ready", 64'(ready[2]), 64'h0);
    check("midreset/result", get_res(2), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      seen |= ready[2];
    end
    check("midreset/no_ready", 64'(seen), 64'h0);

    // Random operations on every configuration.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++) begin
        rop = 2'($urandom_range(0, 3));
        ra  = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       rb = 64'h0;
          1:       rb = 64'($urandom_range(1, 15));
          2:       rb = {32'h0, $urandom};
          default: rb = {$urandom, $urandom};
        endcase
        tick(1);
        do_op(d, rop, ra, rb, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divider_xlen.md
DIVIDER_XLEN -- requirements
Module: divider_xlen

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width; legal values 32 or 64.
REQ-002 The block SHALL have parameter UNROLL, default 1, meaning restoring-division steps per cycle; legal values 1, 2 or 4, and XLEN % UNROLL == 0.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port dec_start_div  input  1  meaning initiate a DIV/REM operation.
REQ-006 The block SHALL have port dec_div_opc  input  2  meaning 0 DIV, 1 DIVU, 2 REM, 3 REMU.
REQ-007 The block SHALL have ports dec_src1 / dec_src2  input  XLEN  meaning dividend / divisor.
REQ-008 The block SHALL have ports dec_rs1 / dec_rs2  input  5  meaning source register numbers.
REQ-009 The block SHALL have port wrb_restart  input  1  meaning abort any operation and invalidate the cache.
REQ-010 The block SHALL have port div_busy  output  1  meaning high in ITER or FIX.
REQ-011 The block SHALL have port div_ready  output  1  meaning high in DONE.
REQ-012 The block SHALL have port div_result  output  XLEN  meaning the quotient (opc[1]=0) or remainder (opc[1]=1) of the latched opcode.

Function
REQ-013 The FSM SHALL have states IDLE, ITER, FIX, DONE.
REQ-014 In IDLE or DONE with dec_start_div=1 and wrb_restart=0, the block SHALL latch opc, rs1, rs2 and, on a non-special cache miss, latch operand magnitudes and signs, then go to ITER.
REQ-015 Signed ops SHALL divide |src1| by |src2| unsigned; sign handling: quotient negated when signs differ, remainder takes the sign of src1.
REQ-016 ITER SHALL perform UNROLL restoring steps per cycle for exactly XLEN/UNROLL cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction to both quotient and remainder, store both, set cache_valid, and go to DONE.
REQ-018 Computed-op latency: start accepted in cycle T SHALL give div_ready=1 in cycle T+XLEN/UNROLL+2 (T+34 for 32/1).
REQ-019 Divisor zero SHALL bypass to DONE at T+1 with quotient = all ones and remainder = src1, for all opcodes.
REQ-020 Signed overflow (DIV/REM, src1 = most-negative, src2 = -1) SHALL bypass to DONE at T+1 with quotient = src1 and remainder = 0.
REQ-021 Cache hit SHALL be defined as: state DONE, cache_valid=1, and equal rs1, rs2 and opc[0]. On a hit, the block SHALL stay in DONE, update only opc, and present the other result at T+1.
REQ-022 DONE without a new start SHALL go to IDLE in the next cycle; div_result SHALL hold its value until the next state change.
REQ-023 wrb_restart in any state SHALL force IDLE next cycle and clear cache_valid; it has priority over dec_start_div.
REQ-024 dec_start_div while div_busy=1 SHALL be ignored with no state change.
REQ-025 Remainder width SHALL be XLEN+1 bits internally so that no borrow is lost at XLEN=64.

Reset
REQ-026 While reset=1, the block SHALL go to IDLE with div_busy=0, div_ready=0, div_result=0, cache_valid=0, and all datapath registers zero.
REQ-027 Reset mid-operation SHALL discard the operation, and no div_ready SHALL follow.

Structure
REQ-028 The state encoding, opcode constants (DIV/DIVU/REM/REMU) and legal-parameter checks SHALL reside in the shared package div_pkg.
REQ-029 One UNROLL-step combinational sub-module, div_step, SHALL be instantiated UNROLL times in a chain.
REQ-030 Illegal parameters SHALL be rejected at elaboration.

Verification
REQ-031 Test: DIVU 100/7, XLEN=32, UNROLL=1 -> div_ready at T+34, result 14; then REMU with same rs -> result 2 at T+1.
REQ-032 Test: DIV -7/2 -> result -3 (0xFFFFFFFD); REM -7/2 -> result -1; UNROLL=4 -> ready at T+10.
REQ-033 Test: DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5.
REQ-034 Test: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; both at T+1.
REQ-035 Test: wrb_restart at ITER cycle 10 -> IDLE next cycle, div_busy=0, and a following REM with same rs misses the cache (full latency).
REQ-036 Test: XLEN=64 DIVU 0xFFFFFFFFFFFFFFFF/3 -> 0x5555555555555555 at T+66; reset asserted mid-ITER -> all outputs 0 next cycle.
